// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one combinational signed 32x32 multiplier between two requesters.
//   Requests are arbitrated round-robin in IDLE. The winner's operands are
//   registered and held for CALC_CYCLES cycles so the multiplier can be timed
//   as a multicycle path. The 64-bit product is then held on a valid/ready
//   response port, tagged with the id of the requester that owns it.
//
//   Ports:
//     clk, rst                 clock (rising edge), synchronous active-high reset
//     req0_valid/ready/a/b     requester 0 operand handshake and operands
//     req1_valid/ready/a/b     requester 1 operand handshake and operands
//     rsp_valid/ready          product handshake
//     rsp_id                   requester that owns rsp_p
//     rsp_p                    signed 2*WIDTH product
//     busy                     high whenever the FSM is not in IDLE
//
//   WIDTH must be 32 (fixed by simple_multiplier); CALC_CYCLES in 1..15.

module simple_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  // Sign-extend both operands to 64 bits so the product is exact.
  assign p = 64'($signed(a)) * 64'($signed(b));
endmodule

module mult_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int CALC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_p,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  localparam int CW = 4;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               rr;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] product;
  logic               gnt0;
  logic               gnt1;

  simple_multiplier u_mul (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  // Grant is only offered in IDLE. With both requesters valid, rr picks the
  // winner; rr is flipped away from the last served requester on each response.
  // Ready is masked during reset so no requester believes it was accepted on
  // an edge where the reset discards the transaction.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && (!req1_valid || !rr)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_a   <= gnt1 ? req1_a : req0_a;
            op_b   <= gnt1 ? req1_b : req0_b;
            rsp_id <= gnt1;
            cnt    <= CW'(CALC_CYCLES - 1);
            state  <= CALC;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_p     <= product;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr        <= ~rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Scoreboard bench. An input monitor predicts every grant from the
//   round-robin rule and pushes the expected product (plain integer
//   multiplication) into a queue; an output monitor pops and compares on each
//   response. Directed cases are followed by a randomized phase.

module tb_mult_share_arbiter;

  localparam int CALC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  v;
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [63:0] rsp_p;
  bit          rand_rdy;

  mult_share_arbiter #(.WIDTH(32), .CALC_CYCLES(CALC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v[0]),
    .req0_ready (req0_ready),
    .req0_a     (a[0]),
    .req0_b     (b[0]),
    .req1_valid (v[1]),
    .req1_ready (req1_ready),
    .req1_a     (a[1]),
    .req1_b     (b[1]),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_p      (rsp_p),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [63:0] p;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endfunction

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  // Reference model state: pend = a transaction is owned by the block,
  // rr_m = requester that wins a tie. Releases arrive from the output monitor.
  bit pend = 1'b0;
  bit rr_m = 1'b0;
  int rel_count = 0;
  int rel_seen  = 0;
  bit rel_id    = 1'b0;

  always @(negedge clk) begin : imon
    bit g0, g1;
    if (rel_count != rel_seen) begin
      rel_seen = rel_count;
      pend     = 1'b0;
      rr_m     = ~rel_id;
    end
    if (rst) begin
      pend = 1'b0;
      rr_m = 1'b0;
      q.delete();
    end else begin
      chk("busy", 64'(busy), 64'(pend));
      g0 = !pend && v[0] && (!v[1] || !rr_m);
      g1 = !pend && v[1] && !g0;
      chk("req0_ready", 64'(req0_ready), 64'(g0));
      chk("req1_ready", 64'(req1_ready), 64'(g1));
      if (g0 || g1) begin
        q.push_back('{id: g1, p: prod(a[g1], b[g1]), acc: cyc + 1});
        pend = 1'b1;
      end
    end
  end

  bit first_seen = 1'b0;

  always @(negedge clk) begin : omon
    if (rst) begin
      first_seen = 1'b0;
    end else if (rsp_valid) begin
      if (q.size() == 0) begin
        chk("spurious_rsp_valid", 64'(rsp_valid), 64'd0);
      end else begin
        if (!first_seen) begin
          chk("latency", 64'(cyc - q[0].acc), 64'(CALC));
          first_seen = 1'b1;
        end
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_p", rsp_p, q[0].p);
        if (rsp_ready) begin
          rel_id    <= q[0].id;
          rel_count <= rel_count + 1;
          void'(q.pop_front());
          first_seen = 1'b0;
        end
      end
    end else if (q.size() != 0 && (cyc - q[0].acc) > CALC) begin
      chk("rsp_valid_late", 64'(rsp_valid), 64'd1);
      rel_id    <= q[0].id;
      rel_count <= rel_count + 1;
      void'(q.pop_front());
      first_seen = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [31:0] x, input logic [31:0] y, input bit keep);
    int  n;
    bit  rdy;
    n = 0;
    v[id] = 1'b1;
    a[id] = x;
    b[id] = y;
    do begin
      @(negedge clk);
      n++;
      rdy = (id == 0) ? req0_ready : req1_ready;
    end while (!rdy && n < 500);
    if (!rdy) chk("send_timeout", 64'(rdy), 64'd1);
    @(posedge clk);
    #1;
    if (!keep) v[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || busy) && n < 500);
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk("rsp_wait_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_p", rsp_p, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    v         = '0;
    a[0]      = '0; a[1] = '0;
    b[0]      = '0; b[1] = '0;
    rsp_ready = 1'b0;
    rand_rdy  = 1'b0;
    tick(2);
    rst = 1'b0;
    check_reset_outputs();

    // Single requests, each requester alone.
    rsp_ready = 1'b1;
    send(0, 32'd20, 32'd75, 1'b0);
    wait_idle();
    send(1, 32'hFFFF_FFD5, 32'hFFFF_FFD0, 1'b0);
    wait_idle();

    // Both valid right after reset: requester 0 first, then 1.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    fork
      send(0, 32'd23, 32'hFFFF_FFF1, 1'b0);
      send(1, 32'd125, 32'hFFFF_FFEE, 1'b0);
    join
    wait_idle();

    // Continuous valid on both sides: strict alternation.
    fork
      for (int i = 0; i < 4; i++) send(0, rnd_op(), rnd_op(), i < 3);
      for (int j = 0; j < 4; j++) send(1, rnd_op(), rnd_op(), j < 3);
    join
    wait_idle();

    // Backpressure with a short-lived request from 1 during CALC, then a
    // real request from 1 that must wait out the held response.
    rsp_ready = 1'b0;
    fork
      send(0, 32'hFFFF_FFE7, 32'd30, 1'b0);
      begin
        tick(1);
        v[1] = 1'b1; a[1] = 32'd99; b[1] = 32'd99;
        tick(1);
        v[1] = 1'b0;
        tick(1);
        send(1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      end
      begin
        wait_rsp();
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset while in CALC discards the transaction.
    send(0, 32'd10, 32'd0, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_outputs();
    tick(CALC + 3);
    send(0, 32'd10, 32'd1, 1'b0);
    wait_idle();

    // Reset while in RESP discards the held response.
    rsp_ready = 1'b0;
    send(1, 32'd7, 32'd6, 1'b0);
    wait_rsp();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    check_reset_outputs();
    tick(3);

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    fork
      for (int i = 0; i < 25; i++) begin
        tick($urandom_range(0, 3));
        send(0, rnd_op(), rnd_op(), 1'b0);
      end
      for (int j = 0; j < 25; j++) begin
        tick($urandom_range(0, 3));
        send(1, rnd_op(), rnd_op(), 1'b0);
      end
    join
    rand_rdy = 1'b0;
    tick(1);
    rsp_ready = 1'b1;
    wait_idle();
    tick(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
